alu_sequencer: RTL and testbench

//  Command sequencer that owns the shared 8-bit ALU (AND/OR/ADD/SUB, 2-bit ALUControl).

---
 rtl/alu_sequencer_if.sv | 26 ++
 rtl/alu_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between the issuing logic and alu_sequencer.
// master = issuer (drives commands, accepts responses); slave = sequencer.
interface alu_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequencer owning a shared AND/OR/ADD/SUB ALU. Takes one command at a time,
// drives SrcA/SrcB/ALUControl, and returns result/zero/err on a response port.
// Optional feature macro: ALU_SEQ_MUL_EN builds the MUL op (repeated ADD on
// the ALU). Without it, op 4 is answered as illegal.
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    alu_sequencer_if.slave   bus,
    output logic             busy,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [1:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             Zero
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b10;

    state_t           r_state;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_err;
    // ALU drive registers double as the latched operands; in MUL, r_src_a is
    // the running accumulator and r_src_b holds the multiplicand.
    logic [WIDTH-1:0] r_src_a;
    logic [WIDTH-1:0] r_src_b;
    logic [1:0]       r_alu_ctrl;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] r_cnt;
`endif

    logic w_accept;
    assign w_accept = bus.cmd_valid & r_cmd_ready;

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_err    = r_rsp_err;
    assign busy           = r_busy;
    assign SrcA           = r_src_a;
    assign SrcB           = r_src_b;
    assign ALUControl     = r_alu_ctrl;

    // Single-process FSM: state, handshake flags, ALU drive and response registers.
    // NOTE: every state element here uses non-blocking assignment so all
    // registers update together from pre-edge values; blocking would let later
    // statements see the new state within the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_src_a      <= '0;
            r_src_b      <= '0;
            r_alu_ctrl   <= 2'b00;
`ifdef ALU_SEQ_MUL_EN
            r_cnt        <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (!bus.cmd_op[2]) begin
                            r_state    <= ST_EXEC;
                            r_src_a    <= bus.cmd_a;
                            r_src_b    <= bus.cmd_b;
                            r_alu_ctrl <= bus.cmd_op[1:0];
                        end
`ifdef ALU_SEQ_MUL_EN
                        else if (bus.cmd_op == 3'd4 && bus.cmd_b != '0) begin
                            r_state    <= ST_MUL;
                            r_src_a    <= '0;
                            r_src_b    <= bus.cmd_a;
                            r_alu_ctrl <= ALU_ADD;
                            r_cnt      <= bus.cmd_b;
                        end else if (bus.cmd_op == 3'd4) begin
                            // Multiply by zero needs no ALU pass.
                            r_state      <= ST_DONE;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= '0;
                            r_rsp_zero   <= 1'b1;
                            r_rsp_err    <= 1'b0;
                        end
`endif
                        else begin
                            r_state      <= ST_DONE;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= '0;
                            r_rsp_zero   <= 1'b0;
                            r_rsp_err    <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_state      <= ST_DONE;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= ALUResult;
                    r_rsp_zero   <= Zero;
                    r_rsp_err    <= 1'b0;
                    r_src_a      <= '0;
                    r_src_b      <= '0;
                    r_alu_ctrl   <= 2'b00;
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    if (r_cnt == WIDTH'(1)) begin
                        r_state      <= ST_DONE;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= ALUResult;
                        r_rsp_zero   <= Zero;
                        r_rsp_err    <= 1'b0;
                        r_src_a      <= '0;
                        r_src_b      <= '0;
                        r_alu_ctrl   <= 2'b00;
                    end else begin
                        r_src_a <= ALUResult;
                        r_cnt   <= r_cnt - WIDTH'(1);
                    end
                end
`endif
                ST_DONE: begin
                    // Response held stable until the consumer takes it.
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_src_a     <= '0;
                    r_src_b     <= '0;
                    r_alu_ctrl  <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. A behavioural ALU closes the loop on
// SrcA/SrcB/ALUControl. Latency is counted in rising edges starting with the
// accept edge as 1. MUL scenarios are selected by ALU_SEQ_MUL_EN.
module tb_alu_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         busy;
    logic [W-1:0] src_a, src_b, alu_result;
    logic [1:0]   alu_ctrl;
    logic         zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.WIDTH(W)) bus ();

    alu_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (alu_ctrl),
        .ALUResult  (alu_result),
        .Zero       (zero)
    );

    // Shared ALU the sequencer owns.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            2'b00:   alu_result = src_a & src_b;
            2'b01:   alu_result = src_a | src_b;
            2'b10:   alu_result = src_a + src_b;
            default: alu_result = src_a - src_b;
        endcase
    end
    assign zero = (alu_result == '0);

    // Issue one command; return edges-to-rsp_valid and the ALU drive seen just after accept.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] sa, output logic [W-1:0] sb,
                          output logic [1:0] ctl);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd2;
        bus.cmd_a     = 8'hEE;
        bus.cmd_b     = 8'hDD;
        lat = 1;
        sa  = src_a;
        sb  = src_b;
        ctl = alu_ctrl;
        while (!bus.rsp_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.rsp_valid) begin
            $display("FAIL timeout op=%0d: rsp_valid never rose within %0d edges", op, lat);
            bad++;
            total++;
        end
    endtask

    // Complete the response handshake; returns sampled #1 after the handshake edge.
    task automatic rsp_handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        total++; if (bus.rsp_valid !== 1'b0) begin $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); bad++; end
        total++; if (bus.rsp_result !== 8'h00) begin $display("FAIL reset_rsp_result got=%h want=00", bus.rsp_result); bad++; end
        total++; if ({bus.rsp_zero, bus.rsp_err, busy} !== 3'b000) begin $display("FAIL reset_flags got=%b want=000", {bus.rsp_zero, bus.rsp_err, busy}); bad++; end
        total++; if ({src_a, src_b, alu_ctrl} !== 18'h0) begin $display("FAIL reset_alu_drive got=%h want=0", {src_a, src_b, alu_ctrl}); bad++; end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.cmd_ready !== 1'b1) begin $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); bad++; end
    endtask

    task automatic test_single_ops();
        logic [2:0]   ops  [4] = '{3'd2,  3'd3,  3'd0,  3'd1};
        logic [W-1:0] va   [4] = '{8'h7F, 8'h33, 8'hF0, 8'hA0};
        logic [W-1:0] vb   [4] = '{8'h01, 8'h33, 8'h0F, 8'h05};
        logic [W-1:0] vres [4] = '{8'h80, 8'h00, 8'h00, 8'hA5};
        logic         vz   [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
        int lat;
        logic [W-1:0] sa, sb;
        logic [1:0] ctl;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], va[i], vb[i], lat, sa, sb, ctl);
            total++; if (lat !== 2) begin $display("FAIL op%0d_latency got=%0d want=2", ops[i], lat); bad++; end
            total++; if ({sa, sb, ctl} !== {va[i], vb[i], ops[i][1:0]}) begin $display("FAIL op%0d_alu_drive got=%h/%h/%b want=%h/%h/%b", ops[i], sa, sb, ctl, va[i], vb[i], ops[i][1:0]); bad++; end
            total++; if (bus.rsp_result !== vres[i]) begin $display("FAIL op%0d_result got=%h want=%h", ops[i], bus.rsp_result, vres[i]); bad++; end
            total++; if ({bus.rsp_zero, bus.rsp_err} !== {vz[i], 1'b0}) begin $display("FAIL op%0d_zero_err got=%b want=%b0", ops[i], {bus.rsp_zero, bus.rsp_err}, vz[i]); bad++; end
            total++; if ({src_a, src_b, alu_ctrl} !== 18'h0) begin $display("FAIL op%0d_done_drive got=%h want=0", ops[i], {src_a, src_b, alu_ctrl}); bad++; end
            rsp_handshake();
            total++; if ({bus.rsp_valid, bus.cmd_ready, busy} !== 3'b010) begin $display("FAIL op%0d_return_idle got=%b want=010", ops[i], {bus.rsp_valid, bus.cmd_ready, busy}); bad++; end
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [W-1:0] sa, sb;
        logic [1:0] ctl;
`ifdef ALU_SEQ_MUL_EN
        logic [W-1:0] ma   [3] = '{8'h10, 8'h03, 8'h80};
        logic [W-1:0] mb   [3] = '{8'h11, 8'h05, 8'h02};
        logic [W-1:0] mres [3] = '{8'h10, 8'h0F, 8'h00};
        logic         mz   [3] = '{1'b0,  1'b0,  1'b1};
        int           mlat [3] = '{18, 6, 3};
        for (int i = 0; i < 3; i++) begin
            run_op(3'd4, ma[i], mb[i], lat, sa, sb, ctl);
            total++; if (lat !== mlat[i]) begin $display("FAIL mul%0d_latency got=%0d want=%0d", i, lat, mlat[i]); bad++; end
            total++; if ({sa, sb, ctl} !== {8'h00, ma[i], 2'b10}) begin $display("FAIL mul%0d_first_drive got=%h/%h/%b want=00/%h/10", i, sa, sb, ctl, ma[i]); bad++; end
            total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {mres[i], mz[i], 1'b0}) begin $display("FAIL mul%0d_rsp got=%h z%b e%b want=%h z%b e0", i, bus.rsp_result, bus.rsp_zero, bus.rsp_err, mres[i], mz[i]); bad++; end
            rsp_handshake();
        end
        run_op(3'd4, 8'h5A, 8'h00, lat, sa, sb, ctl);
        total++; if (lat !== 1) begin $display("FAIL mul_b0_latency got=%0d want=1", lat); bad++; end
        total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {8'h00, 1'b1, 1'b0}) begin $display("FAIL mul_b0_rsp got=%h z%b e%b want=00 z1 e0", bus.rsp_result, bus.rsp_zero, bus.rsp_err); bad++; end
        rsp_handshake();
`else
        run_op(3'd4, 8'h10, 8'h11, lat, sa, sb, ctl);
        total++; if (lat !== 1) begin $display("FAIL op4_disabled_latency got=%0d want=1", lat); bad++; end
        total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {8'h00, 1'b0, 1'b1}) begin $display("FAIL op4_disabled_rsp got=%h z%b e%b want=00 z0 e1", bus.rsp_result, bus.rsp_zero, bus.rsp_err); bad++; end
        total++; if ({sa, sb, ctl} !== 18'h0) begin $display("FAIL op4_disabled_drive got=%h want=0", {sa, sb, ctl}); bad++; end
        rsp_handshake();
`endif
    endtask

    task automatic test_illegal();
        int lat;
        logic [W-1:0] sa, sb;
        logic [1:0] ctl;
        for (int op = 5; op < 8; op++) begin
            run_op(3'(op), 8'hFF, 8'h01, lat, sa, sb, ctl);
            total++; if (lat !== 1) begin $display("FAIL illegal%0d_latency got=%0d want=1", op, lat); bad++; end
            total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {8'h00, 1'b0, 1'b1}) begin $display("FAIL illegal%0d_rsp got=%h z%b e%b want=00 z0 e1", op, bus.rsp_result, bus.rsp_zero, bus.rsp_err); bad++; end
            rsp_handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W-1:0] sa, sb;
        logic [1:0] ctl;
        run_op(3'd2, 8'h12, 8'h34, lat, sa, sb, ctl);
        // A competing command is offered while the response is held; it must be ignored.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd6;
        bus.cmd_a     = 8'h01;
        bus.cmd_b     = 8'h01;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {1'b1, 8'h46, 1'b0, 1'b0}) begin $display("FAIL hold_rsp_c%0d got=%b/%h/%b/%b want=1/46/0/0", c, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err); bad++; end
            total++; if ({bus.cmd_ready, busy} !== 2'b01) begin $display("FAIL hold_ready_c%0d got=%b want=01", c, {bus.cmd_ready, busy}); bad++; end
        end
        bus.cmd_valid = 1'b0;
        rsp_handshake();
        total++; if ({bus.rsp_valid, bus.cmd_ready, busy} !== 3'b010) begin $display("FAIL hold_release got=%b want=010", {bus.rsp_valid, bus.cmd_ready, busy}); bad++; end
        // rsp_ready with no response pending changes nothing.
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        total++; if ({bus.rsp_valid, bus.cmd_ready, busy} !== 3'b010) begin $display("FAIL stray_rsp_ready got=%b want=010", {bus.rsp_valid, bus.cmd_ready, busy}); bad++; end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [W-1:0] sa, sb;
        logic [1:0] ctl;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        bus.cmd_op = 3'd4;
        bus.cmd_a  = 8'h03;
        bus.cmd_b  = 8'd200;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
`else
        bus.cmd_op = 3'd2;
        bus.cmd_a  = 8'h03;
        bus.cmd_b  = 8'h04;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
`endif
        total++; if ({bus.rsp_valid, busy} !== 2'b01) begin $display("FAIL mid_op_busy got=%b want=01", {bus.rsp_valid, busy}); bad++; end
        reset = 1'b0;
        #1;
        total++; if ({bus.rsp_valid, busy, bus.cmd_ready} !== 3'b001) begin $display("FAIL mid_op_abort got=%b want=001", {bus.rsp_valid, busy, bus.cmd_ready}); bad++; end
        total++; if ({src_a, src_b, alu_ctrl} !== 18'h0) begin $display("FAIL mid_op_drive got=%h want=0", {src_a, src_b, alu_ctrl}); bad++; end
        @(negedge clk);
        reset = 1'b1;
        // A held response is discarded by reset.
        run_op(3'd1, 8'h0C, 8'h30, lat, sa, sb, ctl);
        reset = 1'b0;
        #1;
        total++; if ({bus.rsp_valid, bus.rsp_result} !== {1'b0, 8'h00}) begin $display("FAIL held_rsp_discard got=%b/%h want=0/00", bus.rsp_valid, bus.rsp_result); bad++; end
        @(negedge clk);
        reset = 1'b1;
        run_op(3'd2, 8'h05, 8'h06, lat, sa, sb, ctl);
        total++; if (lat !== 2) begin $display("FAIL post_reset_latency got=%0d want=2", lat); bad++; end
        total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {8'h0B, 1'b0, 1'b0}) begin $display("FAIL post_reset_rsp got=%h z%b e%b want=0b z0 e0", bus.rsp_result, bus.rsp_zero, bus.rsp_err); bad++; end
        rsp_handshake();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single_ops();
        test_mul();
        test_illegal();
        test_backpressure();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
